div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Sits in EX between the instruction decode/operand path and the iterative divider.
- Accepts one RV32M divide/remainder request (DIV/DIVU/REM/REMU).
- Drives the divider's start/op/operand inputs, holding start high for the whole operation, and raises a pipeline hold.
- Latches the destination register, captures the divider result on its ready pulse, and issues a single registered regfile write. Handles flush/abort and the divider's one-cycle return-to-idle.

Parameters:
- TIMEOUT_CYC, 64, cycles in BUSY without ready_i before forced abort (error flag set).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- req_valid_i  input  1  EX presents a divide-class instruction this cycle
- req_funct3_i  input  3  funct3 of the instruction (100 DIV, 101 DIVU, 110 REM, 111 REMU)
- req_rs1_i  input  32  dividend operand
- req_rs2_i  input  32  divisor operand
- req_rd_i  input  5  destination register
- flush_i  input  1  jump/interrupt flush; abort any in-flight operation
- div_dividend_o  output  32  to divider dividend_i
- div_divisor_o  output  32  to divider divisor_i
- div_start_o  output  1  to divider start_i
- div_op_o  output  3  to divider op_i
- div_waddr_o  output  5  to divider reg_waddr_i (latched rd)
- div_result_i  input  32  divider result_o
- div_ready_i  input  1  divider ready_o (one-cycle pulse)
- div_busy_i  input  1  divider busy_o
- hold_o  output  1  stall request to the pipeline
- wb_we_o  output  1  regfile write enable (one-cycle pulse)
- wb_waddr_o  output  5  regfile write address
- wb_wdata_o  output  32  regfile write data
- timeout_o  output  1  sticky error flag, cleared by reset only

Behaviour:
- Reset (rst==0 at posedge): state=IDLE. All registered outputs are 0: operand, op, waddr, wb_*, timeout_o. Cycle counter is 0.
- States: IDLE, BUSY, DONE, RECOVER.
- IDLE:
  - Accept when req_valid_i && req_funct3_i[2]==1 && !flush_i.
  - On accept, latch rs1, rs2, funct3, rd; clear counter; go to BUSY.
  - Requests with funct3[2]==0 are ignored: no hold, no write.
- hold_o is combinational: (IDLE && accept) || BUSY || DONE || RECOVER. The pipeline therefore stalls in the accept cycle itself.
- div_start_o is combinational: BUSY && !div_ready_i && !flush_i && !timeout_hit.
  - start drops in the same cycle ready_i is seen, so the divider, now in its idle state, does not restart.
- BUSY:
  - Counter increments every cycle.
  - div_ready_i==1: capture div_result_i into wb_wdata_o; wb_waddr_o <= latched rd; wb_we_o <= (rd!=0); go to DONE.
  - flush_i==1 (takes priority over ready in the same cycle): no write; go to RECOVER.
  - Counter reaches TIMEOUT_CYC-1 without ready: timeout_o <= 1; no write; go to RECOVER.
- DONE: wb_we_o already high for exactly this cycle. Clear wb_we_o and go to IDLE. No new request is accepted in DONE.
- RECOVER: start is low for this cycle so the divider returns to idle. Go to IDLE next cycle. If div_busy_i is still 1, stay in RECOVER, bounded by one extra cycle.
- flush_i in IDLE blocks acceptance. flush_i in DONE does not cancel the already-issued write.
- Operands are presented from the latched registers, never directly from req_*, so operands stay stable while EX is held.
- Zero-divisor and signed-overflow results come from the divider unchanged. This block does no arithmetic.
- Latency from accept to wb_we_o equals divider latency + 1. Back-to-back requests are spaced at least 1 idle cycle apart (the DONE cycle).

Test Plan:
- DIV 100 / 7, rd=5 -> hold_o high from accept to DONE; start high until ready; one wb_we_o pulse, waddr=5, wdata=14; then IDLE.
- REM -7 (0xFFFFFFF9) % 2, rd=3 -> wdata=0xFFFFFFFF. DIVU x / 0 -> wdata=0xFFFFFFFF. REMU 9 % 0 -> wdata=9.
- DIV with rd=0 -> operation completes, hold released, wb_we_o stays 0.
- flush_i asserted 10 cycles into BUSY -> start low next cycle, no write, RECOVER then IDLE. A new DIVU 20/3 two cycles later -> wdata=6.
- flush_i and div_ready_i asserted in the same cycle -> no write; state goes to RECOVER.
- Divider model that never asserts ready, TIMEOUT_CYC=64 -> timeout_o=1 after 64 cycles; start drops; hold released after RECOVER; no write.
- Reset asserted mid-BUSY -> next cycle all outputs 0, state IDLE, hold_o=0.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Bus between the divide issue controller and the iterative divider.
// Handshake: the controller holds div_start_o high for the whole operation
// with operands/op stable; the divider answers with a one-cycle div_ready_i
// pulse carrying div_result_i. The controller drops start in that same cycle.
// Dropping start early aborts the divider, which then returns to idle.
// div_busy_i is high while the divider is computing.
interface div_issue_ctrl_if;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic        div_start_o;
    logic [2:0]  div_op_o;
    logic [4:0]  div_waddr_o;
    logic [31:0] div_result_i;
    logic        div_ready_i;
    logic        div_busy_i;

    modport master (
        output div_dividend_o, div_divisor_o, div_start_o, div_op_o, div_waddr_o,
        input  div_result_i, div_ready_i, div_busy_i
    );

    modport slave (
        input  div_dividend_o, div_divisor_o, div_start_o, div_op_o, div_waddr_o,
        output div_result_i, div_ready_i, div_busy_i
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for RV32M divide/remainder instructions.
// Latches one request, drives the iterative divider, stalls the pipeline
// while the operation is in flight and issues one registered regfile write.
// Handles flush, a busy-cycle timeout and the divider's return to idle.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [31:0]          req_rs1_i,
    input  logic [31:0]          req_rs2_i,
    input  logic [4:0]           req_rd_i,
    input  logic                 flush_i,
    div_issue_ctrl_if.master     div,
    output logic                 hold_o,
    output logic                 wb_we_o,
    output logic [4:0]           wb_waddr_o,
    output logic [31:0]          wb_wdata_o,
    output logic                 timeout_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DONE    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    state_t         state;
    logic [31:0]    rs1_q;
    logic [31:0]    rs2_q;
    logic [2:0]     op_q;
    logic [4:0]     rd_q;
    logic [CW-1:0]  cnt_q;
    logic           rec_extra_q;

    logic           accept;
    logic           timeout_hit;

    // Only divide-class encodings (funct3[2] set) are taken, and never under flush.
    assign accept      = (state == S_IDLE) && req_valid_i && req_funct3_i[2] && !flush_i;
    assign timeout_hit = (state == S_BUSY) && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Stall starts in the accept cycle so EX keeps the instruction until writeback.
    assign hold_o = accept || (state != S_IDLE);

    // Start falls in the ready cycle so the idle divider does not relaunch.
    assign div.div_start_o    = (state == S_BUSY) && !div.div_ready_i && !flush_i && !timeout_hit;
    assign div.div_dividend_o = rs1_q;
    assign div.div_divisor_o  = rs2_q;
    assign div.div_op_o       = op_q;
    assign div.div_waddr_o    = rd_q;
    assign dbg_state_o        = state;

    // Control FSM: latch request, track the operation, issue writeback or recover.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            rec_extra_q <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_waddr_o  <= '0;
            wb_wdata_o  <= '0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rs1_q <= req_rs1_i;
                        rs2_q <= req_rs2_i;
                        op_q  <= req_funct3_i;
                        rd_q  <= req_rd_i;
                        cnt_q <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Flush wins over a coincident ready: the result is dropped.
                    if (flush_i) begin
                        rec_extra_q <= 1'b0;
                        state       <= S_RECOVER;
                    end else if (div.div_ready_i) begin
                        wb_wdata_o <= div.div_result_i;
                        wb_waddr_o <= rd_q;
                        wb_we_o    <= (rd_q != 5'd0);
                        state      <= S_DONE;
                    end else if (timeout_hit) begin
                        timeout_o   <= 1'b1;
                        rec_extra_q <= 1'b0;
                        state       <= S_RECOVER;
                    end
                end
                S_DONE: begin
                    wb_we_o <= 1'b0;
                    state   <= S_IDLE;
                end
                S_RECOVER: begin
                    // Give a still-busy divider at most one more cycle to go idle.
                    if (div.div_busy_i && !rec_extra_q) begin
                        rec_extra_q <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: behavioural divider model on the divider bus,
// randomized requests, scoreboard of expected regfile writes, directed cases
// for flush, flush/ready collision, timeout and reset.
module tb_div_issue_ctrl;

    localparam int TIMEOUT_CYC = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid_i  = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_rs1_i    = '0;
    logic [31:0] req_rs2_i    = '0;
    logic [4:0]  req_rd_i     = '0;
    logic        flush_i      = 1'b0;
    logic        hold_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        timeout_o;
    logic [1:0]  dbg_state_o;

    div_issue_ctrl_if dif();

    div_issue_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_funct3_i(req_funct3_i),
        .req_rs1_i   (req_rs1_i),
        .req_rs2_i   (req_rs2_i),
        .req_rd_i    (req_rd_i),
        .flush_i     (flush_i),
        .div         (dif),
        .hold_o      (hold_o),
        .wb_we_o     (wb_we_o),
        .wb_waddr_o  (wb_waddr_o),
        .wb_wdata_o  (wb_wdata_o),
        .timeout_o   (timeout_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // RV32M divide semantics, including divide-by-zero and signed overflow.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op[1:0])
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- divider model ----------------
    logic [5:0]  lat_cfg     = 6'd4;
    logic        never_ready = 1'b0;
    logic        m_busy;
    logic [5:0]  m_cnt;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    assign dif.div_busy_i = m_busy;

    // Iterative divider: start launches, start low aborts, ready pulses once.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy           <= 1'b0;
            m_cnt            <= '0;
            dif.div_ready_i  <= 1'b0;
            dif.div_result_i <= '0;
        end else begin
            dif.div_ready_i <= 1'b0;
            if (m_busy) begin
                if (!dif.div_start_o) begin
                    m_busy <= 1'b0;
                end else if (m_cnt == 0) begin
                    if (!never_ready) begin
                        dif.div_ready_i  <= 1'b1;
                        dif.div_result_i <= ref_div(m_op, m_a, m_b);
                        m_busy           <= 1'b0;
                    end
                end else begin
                    m_cnt <= m_cnt - 6'd1;
                end
            end else if (dif.div_start_o) begin
                m_busy <= 1'b1;
                m_cnt  <= lat_cfg;
                m_op   <= dif.div_op_o;
                m_a    <= dif.div_dividend_o;
                m_b    <= dif.div_divisor_o;
            end
        end
    end

    // ---------------- monitor ----------------
    // Pops one expected write per wb_we_o pulse; start must be low on ready.
    always @(negedge clk) begin
        if (rst) begin
            if (wb_we_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, wb_waddr_o, wb_wdata_o}, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    check("wb_addr_data", {27'd0, wb_waddr_o, wb_wdata_o}, {27'd0, e});
                end
            end
            if (dif.div_ready_i) check("start_low_on_ready", 64'(dif.div_start_o), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: normal; mode 1: flush at BUSY cycle flush_at; mode 2: flush with ready.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int mode, input int flush_at, input logic [5:0] lat);
        logic prev_flush;
        logic done;
        lat_cfg = lat;
        @(posedge clk); #1;
        req_valid_i  = 1'b1;
        req_funct3_i = op;
        req_rs1_i    = a;
        req_rs2_i    = b;
        req_rd_i     = rd;
        #1;
        check("hold_in_accept", 64'(hold_o), 64'd1);
        if (mode == 0 && rd != 5'd0) exp_q.push_back({rd, ref_div(op, a, b)});
        @(posedge clk); #1;
        // Scramble the request bus so latched operands are what the divider must use.
        req_valid_i  = 1'b0;
        req_rs1_i    = $urandom;
        req_rs2_i    = $urandom;
        req_funct3_i = 3'($urandom_range(0, 7));
        req_rd_i     = 5'($urandom_range(0, 31));
        prev_flush   = 1'b0;
        done         = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (prev_flush) begin
                check("start_low_after_flush", 64'(dif.div_start_o), 64'd0);
                check("hold_in_recover", 64'(hold_o), 64'd1);
            end
            if (!hold_o) begin
                flush_i = 1'b0;
                done    = 1'b1;
                break;
            end
            flush_i    = (mode == 1 && k == flush_at) || (mode == 2 && dif.div_ready_i);
            prev_flush = flush_i;
            @(posedge clk); #1;
        end
        flush_i = 1'b0;
        if (!done) check("hold_release_bound", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hold"}, 64'(hold_o), 64'd0);
        check({tag, "_wb"}, {26'd0, wb_we_o, wb_waddr_o, wb_wdata_o}, 64'd0);
        check({tag, "_timeout"}, 64'(timeout_o), 64'd0);
        check({tag, "_div_bus"}, {dif.div_start_o, dif.div_op_o, dif.div_dividend_o}, 64'd0);
        check({tag, "_div_bus2"}, {27'd0, dif.div_waddr_o, dif.div_divisor_o}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        do_reset();
        check_all_zero("reset");

        // Directed cases.
        do_txn(3'b100, 32'd100, 32'd7, 5'd5, 0, 0, 6'd6);
        do_txn(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 0, 6'd3);
        do_txn(3'b101, 32'h1234_5678, 32'd0, 5'd9, 0, 0, 6'd2);
        do_txn(3'b111, 32'd9, 32'd0, 5'd10, 0, 0, 6'd1);
        do_txn(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0, 6'd0);
        do_txn(3'b100, 32'd50, 32'd5, 5'd0, 0, 0, 6'd4);
        do_txn(3'b100, 32'd1000, 32'd3, 5'd12, 1, 10, 6'd20);
        repeat (1) @(posedge clk);
        do_txn(3'b101, 32'd20, 32'd3, 5'd13, 0, 0, 6'd5);
        do_txn(3'b110, 32'd77, 32'd5, 5'd14, 2, 0, 6'd4);
        do_txn(3'b111, 32'd81, 32'd10, 5'd15, 0, 0, 6'd2);

        // Non-divide funct3 and flushed requests are ignored in IDLE.
        for (int f = 0; f < 4; f++) begin
            @(posedge clk); #1;
            req_valid_i  = 1'b1;
            req_funct3_i = 3'(f);
            #1;
            check("ignore_mul_hold", 64'(hold_o), 64'd0);
        end
        @(posedge clk); #1;
        req_funct3_i = 3'b100;
        flush_i      = 1'b1;
        #1;
        check("flush_blocks_accept", 64'(hold_o), 64'd0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        #1;
        check("flushed_req_not_taken", 64'(hold_o), 64'd0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [31:0] b;
            int sel;
            int mode;
            logic [5:0] lat;
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
            else if (sel == 3) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            lat  = 6'($urandom_range(0, 20));
            sel  = $urandom_range(0, 9);
            mode = (sel < 7) ? 0 : ((sel < 9) ? 1 : 2);
            do_txn({1'b1, 2'($urandom_range(0, 3))}, a, b, 5'($urandom_range(0, 31)),
                   mode, $urandom_range(0, int'(lat) + 1), lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        // Timeout: divider never answers.
        never_ready = 1'b1;
        lat_cfg     = 6'd3;
        @(posedge clk); #1;
        req_valid_i  = 1'b1;
        req_funct3_i = 3'b100;
        req_rs1_i    = 32'd40;
        req_rs2_i    = 32'd4;
        req_rd_i     = 5'd7;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!timeout_o && n < 200) begin
            if (n == TIMEOUT_CYC - 2) check("start_before_timeout", 64'(dif.div_start_o), 64'd1);
            if (n == TIMEOUT_CYC - 1) check("start_drops_on_timeout", 64'(dif.div_start_o), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TIMEOUT_CYC));
        check("timeout_flag", 64'(timeout_o), 64'd1);
        check("hold_after_timeout", 64'(hold_o), 64'd1);
        n = 0;
        while (hold_o && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_released_after_recover", 64'(hold_o), 64'd0);
        never_ready = 1'b0;
        do_txn(3'b101, 32'd99, 32'd10, 5'd20, 0, 0, 6'd3);
        check("timeout_sticky", 64'(timeout_o), 64'd1);

        // Reset in the middle of BUSY.
        lat_cfg = 6'd20;
        @(posedge clk); #1;
        req_valid_i  = 1'b1;
        req_funct3_i = 3'b100;
        req_rs1_i    = 32'd500;
        req_rs2_i    = 32'd6;
        req_rd_i     = 5'd21;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("midbusy_reset");
        repeat (3) @(posedge clk);
        #1;
        do_txn(3'b111, 32'd1234, 32'd100, 5'd22, 0, 0, 6'd2);

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound so a stuck DUT still ends the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
